fmul_seq_ctrl: RTL and testbench
================================

Name: fmul_seq_ctrl

Overview:
- Multi-cycle sequencer that wraps the combinational FP32 multiplier and serves the multi-cycle datapath's control unit.
- Accepts a start pulse with two IEEE-754 single operands and latches them.
- Classifies special operands and drives the latched operands to the multiplier.
- Waits a programmable settle time, then captures the product, fixes up overflow/underflow and specials, and returns a registered result, exception flags and a one-cycle done pulse.

Parameters:
- LAT, 1, cycles the multiplier inputs are held before the product is captured (legal range 1..15).
- QNAN, 32'h7FC00000, canonical quiet NaN returned on invalid operations.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  32  operand A (FP32), sampled with start.
- b  input  32  operand B (FP32), sampled with start.
- fmul_a  output  32  latched operand A, driven to the multiplier.
- fmul_b  output  32  latched operand B, driven to the multiplier.
- fmul_result  input  32  product returned by the multiplier.
- result  output  32  registered final product.
- flag_invalid  output  1  NaN operand, or inf*0.
- flag_overflow  output  1  exponent overflowed; result is ±inf.
- flag_underflow  output  1  exponent underflowed; result is ±0.
- flag_zero  output  1  result is ±0.
- busy  output  1  high in CLASSIFY and COMPUTE.
- done  output  1  one-cycle pulse; result and flags are valid.

Behaviour:
- Reset:
  - Next state is IDLE; the cycle counter clears.
  - result, fmul_a, fmul_b, all flags, busy and done go to 0.
  - Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, CLASSIFY, COMPUTE, DONE.
- IDLE / DONE:
  - If start=1, latch a/b into fmul_a/fmul_b and go to CLASSIFY.
  - Otherwise: DONE goes to IDLE; IDLE stays in IDLE.
  - result and flags hold their values until the next start.
  - Starting from the DONE cycle gives back-to-back operation.
- Operand classes (per operand):
  - zero: exp == 0; denormals are flushed to zero.
  - inf: exp == 255 and mant == 0.
  - nan: exp == 255 and mant != 0.
  - Otherwise normal.
- CLASSIFY (one cycle):
  - Sign s = sa ^ sb.
  - Any NaN, or inf*zero: result = QNAN (sign 0), flag_invalid=1, go to DONE.
  - Else any inf: result = {s, 8'hFF, 23'h0}, go to DONE.
  - Else any zero: result = {s, 31'h0}, flag_zero=1, go to DONE.
  - Else load the counter with LAT-1 and go to COMPUTE.
  - All flags are cleared on entry to CLASSIFY; only the flags listed above are set.
- COMPUTE:
  - Stays LAT cycles; the counter decrements each cycle.
  - When counter == 0, capture fmul_result and go to DONE.
- Exponent fix-up at capture:
  - Compute E = ea + eb - 127 as a signed 10-bit value from the latched operands.
  - If fmul_result[30:23] != E[7:0], the multiplier normalised; E = E + 1.
  - E >= 255: result = {s, 8'hFF, 23'h0}, flag_overflow=1.
  - E <= 0: result = {s, 31'h0}, flag_underflow=1, flag_zero=1.
  - Otherwise: result = {s, E[7:0], fmul_result[22:0]}.
- Latency, with start sampled at edge k:
  - Special operands: done is high in cycle k+2.
  - Normal operands: done is high in cycle k+2+LAT.
- start while busy=1 is ignored; no queuing.
- done and busy are never high in the same cycle.
- fmul_a/fmul_b are stable from the latch until the next accepted start.

Test Plan:
- Simple product, LAT=1: start with a=0x40000000 (2.0), b=0x40400000 (3.0) -> done at k+3, result=0x40C00000, all flags 0.
- Normalising product: a=b=0x3FC00000 (1.5) -> result=0x40100000 (2.25), flags 0.
- Overflow: a=0x7F000000, b=0x40000000 -> result=0x7F800000, flag_overflow=1.
- Underflow: a=0x80800000, b=0x3F000000 -> result=0x80000000, flag_underflow=1, flag_zero=1.
- Specials:
  - a=0x7F800000, b=0x00000000 -> result=0x7FC00000, flag_invalid=1, done at k+2.
  - a=0xC0000000, b=0x00000000 -> result=0x80000000, flag_zero=1.
- Control:
  - start while busy -> ignored, first result unchanged.
  - Back-to-back start in the DONE cycle -> second result correct.
  - Reset asserted in COMPUTE -> no done, all outputs 0 next cycle.

Bench: instantiates the existing combinational multiplier on fmul_a/fmul_b/fmul_result and repeats the first three scenarios with LAT=3 (done at k+5).

Source files
------------

// File: rtl/fmul_seq_ctrl_if.sv
// Handshake and multiplier-facing bus of the FP32 multiply sequencer.
// slave is the sequencer side; master is the requester plus the external multiplier.
interface fmul_seq_ctrl_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] fmul_a;
    logic [31:0] fmul_b;
    logic [31:0] fmul_result;
    logic [31:0] result;
    logic        flag_invalid;
    logic        flag_overflow;
    logic        flag_underflow;
    logic        flag_zero;
    logic        busy;
    logic        done;

    modport slave (
        input  start, a, b, fmul_result,
        output fmul_a, fmul_b, result,
               flag_invalid, flag_overflow, flag_underflow, flag_zero,
               busy, done
    );

    modport master (
        output start, a, b, fmul_result,
        input  fmul_a, fmul_b, result,
               flag_invalid, flag_overflow, flag_underflow, flag_zero,
               busy, done
    );
endinterface

// File: rtl/fmul_seq_ctrl.sv
// Multi-cycle sequencer around a combinational FP32 multiplier: latches operands,
// short-circuits special operands, waits LAT cycles, then fixes up the exponent.
module fmul_seq_ctrl #(
    parameter int unsigned LAT  = 1,
    parameter logic [31:0] QNAN = 32'h7FC00000
) (
    input  logic           clk,
    input  logic           reset,
    fmul_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CLASSIFY, COMPUTE, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;

    logic [7:0] ea, eb;
    logic       sgn;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic       any_nan, any_inf, any_zero, is_invalid, is_special;

    // Bits [33:32] = {overflow, underflow}; [31:0] = fixed-up product.
    function automatic logic [33:0] exp_fixup(input logic [7:0]  xa,
                                              input logic [7:0]  xb,
                                              input logic [31:0] prod,
                                              input logic        s);
        logic signed [9:0] e;
        e = $signed({2'b00, xa}) + $signed({2'b00, xb}) - 10'sd127;
        // The multiplier bumps the exponent when the mantissa product reaches 2.0.
        if (prod[30:23] != e[7:0])
            e = e + 10'sd1;
        if (e >= 10'sd255)
            exp_fixup = {2'b10, s, 8'hFF, 23'h0};
        else if (e <= 10'sd0)
            exp_fixup = {2'b01, s, 31'h0};
        else
            exp_fixup = {2'b00, s, e[7:0], prod[22:0]};
    endfunction

    assign ea       = bus.fmul_a[30:23];
    assign eb       = bus.fmul_b[30:23];
    assign sgn      = bus.fmul_a[31] ^ bus.fmul_b[31];
    assign a_zero   = (ea == 8'h00);
    assign b_zero   = (eb == 8'h00);
    assign a_inf    = (ea == 8'hFF) && (bus.fmul_a[22:0] == 23'h0);
    assign b_inf    = (eb == 8'hFF) && (bus.fmul_b[22:0] == 23'h0);
    assign a_nan    = (ea == 8'hFF) && (bus.fmul_a[22:0] != 23'h0);
    assign b_nan    = (eb == 8'hFF) && (bus.fmul_b[22:0] != 23'h0);
    assign any_nan  = a_nan | b_nan;
    assign any_inf  = a_inf | b_inf;
    assign any_zero = a_zero | b_zero;
    assign is_invalid = any_nan | (a_inf & b_zero) | (b_inf & a_zero);
    assign is_special = any_nan | any_inf | any_zero;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.start) state_nxt = CLASSIFY;
            CLASSIFY: state_nxt = is_special ? DONE : COMPUTE;
            COMPUTE:  if (cnt == 4'd0) state_nxt = DONE;
            DONE:     state_nxt = bus.start ? CLASSIFY : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == CLASSIFY) || (state == COMPUTE);
        bus.done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt                <= 4'd0;
            bus.fmul_a         <= 32'h0;
            bus.fmul_b         <= 32'h0;
            bus.result         <= 32'h0;
            bus.flag_invalid   <= 1'b0;
            bus.flag_overflow  <= 1'b0;
            bus.flag_underflow <= 1'b0;
            bus.flag_zero      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        bus.fmul_a         <= bus.a;
                        bus.fmul_b         <= bus.b;
                        bus.flag_invalid   <= 1'b0;
                        bus.flag_overflow  <= 1'b0;
                        bus.flag_underflow <= 1'b0;
                        bus.flag_zero      <= 1'b0;
                    end
                end
                CLASSIFY: begin
                    if (is_invalid) begin
                        bus.result       <= QNAN;
                        bus.flag_invalid <= 1'b1;
                    end else if (any_inf) begin
                        bus.result <= {sgn, 8'hFF, 23'h0};
                    end else if (any_zero) begin
                        bus.result    <= {sgn, 31'h0};
                        bus.flag_zero <= 1'b1;
                    end else begin
                        cnt <= 4'(LAT - 1);
                    end
                end
                COMPUTE: begin
                    if (cnt == 4'd0) begin
                        {bus.flag_overflow, bus.flag_underflow, bus.result}
                            <= exp_fixup(ea, eb, bus.fmul_result, sgn);
                        bus.flag_zero <= exp_fixup(ea, eb, bus.fmul_result, sgn) >= 34'h1_0000_0000
                                         && exp_fixup(ea, eb, bus.fmul_result, sgn) < 34'h2_0000_0000;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_seq_ctrl.sv
// Scoreboard bench for fmul_seq_ctrl: one LAT=1 and one LAT=3 instance,
// each fed by a truncating behavioural FP32 multiplier.
module tb_fmul_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst3;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    fmul_seq_ctrl_if if1();
    fmul_seq_ctrl_if if3();

    fmul_seq_ctrl #(.LAT(1)) dut1 (.clk(clk), .reset(rst1), .bus(if1));
    fmul_seq_ctrl #(.LAT(3)) dut3 (.clk(clk), .reset(rst3), .bus(if3));

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        int          due;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        p = {24'h0, 1'b1, x[22:0]} * {24'h0, 1'b1, y[22:0]};
        e = {2'b00, x[30:23]} + {2'b00, y[30:23]} - 10'd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'd1;
        end else begin
            m = p[45:23];
        end
        return {x[31] ^ y[31], e[7:0], m};
    endfunction

    always_comb if1.fmul_result = fp_mul(if1.fmul_a, if1.fmul_b);
    always_comb if3.fmul_result = fp_mul(if3.fmul_a, if3.fmul_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst1 && if1.done) begin
            if (q1.size() == 0) begin
                check("l1_unexpected_done", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("l1_result", if1.result, e1.res);
                check("l1_flags", {28'h0, if1.flag_invalid, if1.flag_overflow,
                                   if1.flag_underflow, if1.flag_zero}, {28'h0, e1.flags});
                check("l1_latency", cyc, e1.due);
                check("l1_busy_with_done", {31'h0, if1.busy}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst3 && if3.done) begin
            if (q3.size() == 0) begin
                check("l3_unexpected_done", 32'd1, 32'd0);
            end else begin
                e3 = q3.pop_front();
                check("l3_result", if3.result, e3.res);
                check("l3_flags", {28'h0, if3.flag_invalid, if3.flag_overflow,
                                   if3.flag_underflow, if3.flag_zero}, {28'h0, e3.flags});
                check("l3_latency", cyc, e3.due);
                check("l3_busy_with_done", {31'h0, if3.busy}, 32'd0);
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following the accepting edge.
    task automatic op(input int which, input logic [31:0] xa, input logic [31:0] xb,
                      input logic [31:0] er, input logic [3:0] ef, input bit special);
        exp_t e;
        int   lat;
        lat = (which == 1) ? 1 : 3;
        if (which == 1) begin
            if1.start = 1'b1; if1.a = xa; if1.b = xb;
        end else begin
            if3.start = 1'b1; if3.a = xa; if3.b = xb;
        end
        @(posedge clk);
        #1;
        e.res   = er;
        e.flags = ef;
        e.due   = cyc + 1 + (special ? 0 : lat);
        if (which == 1) begin
            q1.push_back(e);
            if1.start = 1'b0;
        end else begin
            q3.push_back(e);
            if3.start = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic wait_done(input int which);
        for (int i = 0; i < 40; i++) begin
            if ((which == 1 && if1.done) || (which == 3 && if3.done))
                return;
            @(negedge clk);
        end
        check(which == 1 ? "l1_done_timeout" : "l3_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input int which, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] er, input logic [3:0] ef, input bit special);
        op(which, xa, xb, er, ef, special);
        wait_done(which);
        @(negedge clk);
    endtask

    task automatic check_idle(input int which, input string tag);
        if (which == 1) begin
            check({tag, "_result"}, if1.result, 32'h0);
            check({tag, "_fmul_a"}, if1.fmul_a, 32'h0);
            check({tag, "_fmul_b"}, if1.fmul_b, 32'h0);
            check({tag, "_flags"}, {28'h0, if1.flag_invalid, if1.flag_overflow,
                                    if1.flag_underflow, if1.flag_zero}, 32'h0);
            check({tag, "_busy"}, {31'h0, if1.busy}, 32'h0);
            check({tag, "_done"}, {31'h0, if1.done}, 32'h0);
        end else begin
            check({tag, "_result"}, if3.result, 32'h0);
            check({tag, "_fmul_a"}, if3.fmul_a, 32'h0);
            check({tag, "_fmul_b"}, if3.fmul_b, 32'h0);
            check({tag, "_flags"}, {28'h0, if3.flag_invalid, if3.flag_overflow,
                                    if3.flag_underflow, if3.flag_zero}, 32'h0);
            check({tag, "_busy"}, {31'h0, if3.busy}, 32'h0);
            check({tag, "_done"}, {31'h0, if3.done}, 32'h0);
        end
    endtask

    initial begin
        rst1 = 1'b1; rst3 = 1'b1;
        if1.start = 1'b0; if1.a = 32'h0; if1.b = 32'h0;
        if3.start = 1'b0; if3.a = 32'h0; if3.b = 32'h0;
        repeat (3) @(negedge clk);
        check_idle(1, "l1_reset");
        check_idle(3, "l3_reset");
        rst1 = 1'b0; rst3 = 1'b0;
        @(negedge clk);

        // LAT=1: main products and specials
        run(1, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 1'b0);
        run(1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, 1'b0);
        run(1, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0100, 1'b0);
        run(1, 32'h80800000, 32'h3F000000, 32'h80000000, 4'b0011, 1'b0);
        run(1, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1'b1);
        run(1, 32'hC0000000, 32'h00000000, 32'h80000000, 4'b0001, 1'b1);
        run(1, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1'b1);
        run(1, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1'b1);
        run(1, 32'h00000001, 32'h40000000, 32'h00000000, 4'b0001, 1'b1);

        // start while busy is ignored
        op(1, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 1'b0);
        if1.start = 1'b1; if1.a = 32'h7F800000; if1.b = 32'h00000000;
        @(posedge clk);
        #1;
        if1.start = 1'b0;
        check("l1_busy_hold_a", if1.fmul_a, 32'h40000000);
        check("l1_busy_hold_b", if1.fmul_b, 32'h40400000);
        wait_done(1);
        repeat (3) @(negedge clk);
        check("l1_result_hold", if1.result, 32'h40C00000);

        // back-to-back from the DONE cycle; flags must clear for the second op
        op(1, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0100, 1'b0);
        wait_done(1);
        op(1, 32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 1'b0);
        wait_done(1);
        op(1, 32'h00000000, 32'h3F800000, 32'h00000000, 4'b0001, 1'b1);
        wait_done(1);
        @(negedge clk);

        // LAT=3 repeats of the first scenarios
        run(3, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 1'b0);
        run(3, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, 1'b0);
        run(3, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0100, 1'b0);

        // reset during COMPUTE aborts with no done
        if3.start = 1'b1; if3.a = 32'h40000000; if3.b = 32'h40400000;
        @(posedge clk);
        #1;
        if3.start = 1'b0;
        repeat (2) @(negedge clk);
        check("l3_abort_busy", {31'h0, if3.busy}, 32'd1);
        rst3 = 1'b1;
        @(negedge clk);
        check_idle(3, "l3_abort");
        rst3 = 1'b0;
        repeat (8) @(negedge clk);
        run(3, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 1'b0);

        for (int i = 0; i < 50 && (q1.size() != 0 || q3.size() != 0); i++)
            @(negedge clk);
        check("l1_drain", q1.size(), 32'd0);
        check("l3_drain", q3.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
